// File: rtl/spi_adc_scanner.sv
// SPI leader for MCP3002-class SAR ADCs: periodic frame launch, round-robin channel
// scan and full-resolution capture of each conversion tagged with its channel.
//
// state    | meaning
// ST_IDLE  | CS high, waiting for a period tick
// ST_SHIFT | CS low, clocking FRAME serial bits out/in
// ST_HOLD  | CS high, enforcing the minimum deselect time
module spi_adc_scanner #(
   parameter int CLK_DIV       = 8,
   parameter int DATA_BITS     = 10,
   parameter int NUM_CH        = 2,
   parameter int SAMPLE_PERIOD = 1600,
   parameter int CS_HIGH_CYC   = 16
) (
   input  logic                 CLK_50MHz,
   input  logic                 RESET,
   input  logic                 enable,
   input  logic                 diff_mode,
   output logic                 CLKsample,
   output logic                 Din,
   input  logic                 Dout,
   output logic                 CS,
   output logic [DATA_BITS-1:0] sample_word,
   output logic                 sample_ch,
   output logic                 sample_valid,
   output logic                 busy,
   output logic                 overrun
);
   localparam int FRAME  = 5 + DATA_BITS;
   localparam int TMR_W  = $clog2(SAMPLE_PERIOD + 1);
   localparam int DIV_W  = $clog2(CLK_DIV + 1);
   localparam int BIT_W  = $clog2(FRAME + 1);
   localparam int HOLD_W = $clog2(CS_HIGH_CYC + 1);

   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SAMPLE_PERIOD - 1);
   localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME - 1);
   localparam logic [BIT_W-1:0]  BIT_DATA0 = BIT_W'(5);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CS_HIGH_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_RST  = HOLD_W'(CS_HIGH_CYC);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;

   state_t               state, state_nxt;
   logic [TMR_W-1:0]     period_cnt;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [DATA_BITS-1:0] data_sr;
   logic                 cur_ch, next_ch;
   logic                 tick, launch, sclk_edge, rise, fall, last_fall, hold_tc;

   // Command bits: start, SGL/DIFF, channel, MSBF, then ones while data streams back.
   function automatic logic din_bit(input logic [BIT_W-1:0] idx, input logic diff,
                                    input logic ch);
      if (idx == BIT_W'(1)) return !diff;
      else if (idx == BIT_W'(2)) return ch;
      else return 1'b1;
   endfunction

   assign tick      = enable && (period_cnt == '0);
   assign launch    = (state == ST_IDLE) && tick;
   assign sclk_edge = (state == ST_SHIFT) && (div_cnt == '0);
   assign rise      = sclk_edge && !CLKsample;
   assign fall      = sclk_edge && CLKsample;
   assign last_fall = fall && (bit_idx == BIT_LAST);
   assign hold_tc   = (hold_cnt == '0);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge CLK_50MHz) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (tick)      state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_fall) state_nxt = ST_HOLD;
         ST_HOLD:  if (hold_tc)   state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_50MHz) begin
      if (RESET) begin
         period_cnt   <= '0;
         div_cnt      <= '0;
         bit_idx      <= '0;
         hold_cnt     <= HOLD_RST;
         data_sr      <= '0;
         cur_ch       <= 1'b0;
         next_ch      <= 1'b0;
         CS           <= 1'b1;
         CLKsample    <= 1'b0;
         Din          <= 1'b0;
         sample_word  <= '0;
         sample_ch    <= 1'b0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;

         if (!enable)                    period_cnt <= '0;
         else if (period_cnt == TMR_LAST) period_cnt <= '0;
         else                             period_cnt <= period_cnt + 1'b1;

         if (!enable)           overrun <= 1'b0;
         else if (tick && busy) overrun <= 1'b1;

         if (launch) begin
            CS        <= 1'b0;
            Din       <= 1'b1;
            CLKsample <= 1'b0;
            div_cnt   <= DIV_LOAD;
            bit_idx   <= '0;
            cur_ch    <= next_ch;
         end

         if (sclk_edge) begin
            div_cnt   <= DIV_LOAD;
            CLKsample <= !CLKsample;
         end else if (state == ST_SHIFT) begin
            div_cnt <= div_cnt - 1'b1;
         end

         // Null bit and command slots are skipped; only conversion bits shift in.
         if (rise && (bit_idx >= BIT_DATA0))
            data_sr <= {data_sr[DATA_BITS-2:0], Dout};

         if (last_fall) begin
            CS           <= 1'b1;
            Din          <= 1'b0;
            sample_word  <= data_sr;
            sample_ch    <= cur_ch;
            sample_valid <= 1'b1;
            next_ch      <= (NUM_CH == 2) ? !cur_ch : 1'b0;
            hold_cnt     <= HOLD_LOAD;
         end else if (fall) begin
            bit_idx <= bit_idx + 1'b1;
            Din     <= din_bit(bit_idx + 1'b1, diff_mode, cur_ch);
         end

         if ((state == ST_HOLD) && !hold_tc)
            hold_cnt <= hold_cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_spi_adc_scanner.sv
// Bench for spi_adc_scanner: two instances (default 2-channel scan, and a 1-channel
// 12-bit variant with a short sample period) checked every cycle against a frame-timing model.
module tb_spi_adc_scanner;
   localparam int CD = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en   [2];
   logic diff [2];
   bit   rand_mode = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #10 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input int g, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, g, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int DB        = (g == 0) ? 10 : 12;
      localparam int NC        = (g == 0) ? 2 : 1;
      localparam int SP        = (g == 0) ? 1600 : 200;
      localparam int HC        = 16;
      localparam int FR        = 5 + DB;
      localparam int SHIFT_END = 2 * CD * FR;
      localparam int BUSY_END  = SHIFT_END + HC;

      logic          sclk, din, cs, sv, sch, bsy, ovr;
      logic          dout = 1'b0;
      logic [DB-1:0] sw;

      spi_adc_scanner #(
         .CLK_DIV(CD), .DATA_BITS(DB), .NUM_CH(NC), .SAMPLE_PERIOD(SP), .CS_HIGH_CYC(HC)
      ) u_dut (
         .CLK_50MHz(clk), .RESET(rst), .enable(en[g]), .diff_mode(diff[g]),
         .CLKsample(sclk), .Din(din), .Dout(dout), .CS(cs),
         .sample_word(sw), .sample_ch(sch), .sample_valid(sv), .busy(bsy), .overrun(ovr)
      );

      // Model: f = cycles since the launch cycle (-1 when no frame is in flight).
      int            timer = 0;
      int            f = -1;
      bit            nch = 1'b0, fch = 1'b0, fdiff = 1'b0, movr = 1'b0, mch = 1'b0;
      logic [DB-1:0] mword = '0;
      logic [DB-1:0] adc_val [2];

      initial begin
         adc_val[0] = (g == 0) ? DB'(32'h2A5) : DB'(32'hABC);
         adc_val[1] = (g == 0) ? DB'(32'h15A) : DB'(32'h123);
         forever begin
            int fold;
            bit tick;
            @(posedge clk);
            if (rst) begin
               timer = 0; f = -1; nch = 1'b0; movr = 1'b0; mword = '0; mch = 1'b0;
            end else begin
               tick = en[g] && (timer == 0);
               fold = f;
               if (f >= 1) begin
                  f++;
                  if (f > BUSY_END) f = -1;
               end
               if (tick) begin
                  if (fold == -1) begin
                     f = 1; fch = nch; fdiff = diff[g];
                  end else movr = 1'b1;
               end
               if (!en[g]) movr = 1'b0;
               timer = en[g] ? (timer + 1) % SP : 0;
               if (f == SHIFT_END + 1) begin
                  mword = adc_val[fch];
                  mch   = fch;
                  if (NC == 2) nch = !nch;
                  if (rand_mode) adc_val[fch] = DB'($urandom);
               end
            end
         end
      end

      initial forever begin
         bit act, e_sclk, e_din;
         int o, bi;
         @(negedge clk);
         act    = (f >= 1) && (f <= SHIFT_END);
         o      = f - 1;
         bi     = o / (2 * CD);
         e_sclk = act && ((o / CD) % 2 == 1);
         e_din  = act && ((bi == 1) ? !fdiff : (bi == 2) ? fch : 1'b1);
         chk("CS", g, 32'(cs), 32'(!act));
         chk("CLKsample", g, 32'(sclk), 32'(e_sclk));
         chk("Din", g, 32'(din), 32'(e_din));
         chk("sample_valid", g, 32'(sv), 32'(f == SHIFT_END + 1));
         chk("busy", g, 32'(bsy), 32'(f >= 1));
         chk("overrun", g, 32'(ovr), 32'(movr));
         chk("sample_word", g, 32'(sw), 32'(mword));
         chk("sample_ch", g, 32'(sch), 32'(mch));
      end

      // ADC pin model plus frame logs for the directed checks.
      bit            prev_cs = 1'b1, prev_sclk = 1'b0, adc_ch = 1'b0;
      int            nfall = 0, nrise = 0;
      logic [3:0]    cmd = '0;
      int            fall_t [64];
      int            nfalls = 0;
      logic [3:0]    cmd_log [64];
      int            ncmd = 0;
      logic [DB-1:0] word_log [64];
      bit            ch_log [64];
      int            nword = 0;

      initial forever begin
         int k;
         @(negedge clk);
         if (sv) begin
            if (nword < 64) begin word_log[nword] = sw; ch_log[nword] = sch; end
            nword++;
         end
         if (!cs && prev_cs) begin
            if (nfalls < 64) fall_t[nfalls] = cyc;
            nfalls++;
         end
         if (cs) begin
            if (!prev_cs && sv) begin
               chk("rises per frame", g, nrise, FR);
               if (ncmd < 64) cmd_log[ncmd] = cmd;
               ncmd++;
            end
            nfall = 0; nrise = 0; dout = 1'b0;
         end else begin
            if (prev_sclk && !sclk) begin
               nfall++;
               k = nfall;
               dout = (k >= 5 && k < 5 + DB) ? adc_val[adc_ch][DB - 1 - (k - 5)] : 1'b0;
            end
            if (!prev_sclk && sclk) begin
               nrise++;
               k = nfall;
               if (k < 4) cmd[3 - k] = din;
               if (k == 2) adc_ch = din;
            end
         end
         prev_cs   = cs;
         prev_sclk = sclk;
      end
   end

   initial begin
      int bw;
      en[0] = 1'b1; en[1] = 1'b1; diff[0] = 1'b0; diff[1] = 1'b1; rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset CS", 0, 32'(g_inst[0].cs), 32'd1);
      chk("reset CLKsample", 1, 32'(g_inst[1].sclk), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4000 && g_inst[0].nfalls < 3; i++) @(negedge clk);
      chk("three launches", 0, 32'(g_inst[0].nfalls >= 3), 32'd1);
      chk("CS fall spacing", 0, g_inst[0].fall_t[1] - g_inst[0].fall_t[0], 1600);
      chk("CS fall spacing", 0, g_inst[0].fall_t[2] - g_inst[0].fall_t[1], 1600);
      chk("CS fall spacing", 1, g_inst[1].fall_t[1] - g_inst[1].fall_t[0], 400);
      chk("CS fall spacing", 1, g_inst[1].fall_t[2] - g_inst[1].fall_t[1], 400);
      chk("overrun set", 1, 32'(g_inst[1].ovr), 32'd1);
      chk("overrun idle", 0, 32'(g_inst[0].ovr), 32'd0);
      chk("words logged", 0, 32'(g_inst[0].nword >= 2), 32'd1);
      chk("word ch0", 0, 32'(g_inst[0].word_log[0]), 32'h2A5);
      chk("tag ch0", 0, 32'(g_inst[0].ch_log[0]), 32'd0);
      chk("word ch1", 0, 32'(g_inst[0].word_log[1]), 32'h15A);
      chk("tag ch1", 0, 32'(g_inst[0].ch_log[1]), 32'd1);
      chk("cmd ch0", 0, 32'(g_inst[0].cmd_log[0]), 32'b1101);
      chk("cmd ch1", 0, 32'(g_inst[0].cmd_log[1]), 32'b1111);
      chk("cmd diff", 1, 32'(g_inst[1].cmd_log[0]), 32'b1001);
      chk("word diff", 1, 32'(g_inst[1].word_log[0]), 32'hABC);
      chk("tag diff", 1, 32'(g_inst[1].ch_log[1]), 32'd0);

      en[1] = 1'b0;
      @(negedge clk);
      chk("overrun clear", 1, 32'(g_inst[1].ovr), 32'd0);
      en[1] = 1'b1;

      for (int i = 0; i < 2000 && g_inst[0].nfalls < 4; i++) @(negedge clk);
      chk("ch1 frame launched", 0, 32'(g_inst[0].nfalls >= 4), 32'd1);
      for (int i = 0; i < 200 && cyc < g_inst[0].fall_t[3] + 115; i++) @(negedge clk);
      rst = 1'b1; en[0] = 1'b0; en[1] = 1'b0;
      @(negedge clk);
      chk("CS after reset", 0, 32'(g_inst[0].cs), 32'd1);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      bw = g_inst[0].nword;
      en[0] = 1'b1; en[1] = 1'b1;
      for (int i = 0; i < 2000 && g_inst[0].nword <= bw; i++) @(negedge clk);
      chk("sample after reset", 0, 32'(g_inst[0].nword > bw), 32'd1);
      chk("tag after reset", 0, 32'(g_inst[0].ch_log[bw]), 32'd0);
      chk("word after reset", 0, 32'(g_inst[0].word_log[bw]), 32'h2A5);

      rand_mode = 1'b1;
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(1, 900)) @(negedge clk);
         case ($urandom_range(0, 9))
            0, 1: en[0] = !en[0];
            2, 3: en[1] = !en[1];
            4: begin
               rst = 1'b1;
               diff[0] = 1'($urandom_range(0, 1));
               diff[1] = 1'($urandom_range(0, 1));
               repeat ($urandom_range(1, 3)) @(negedge clk);
               rst = 1'b0;
            end
            default: ;
         endcase
      end
      en[0] = 1'b1; en[1] = 1'b1;
      repeat (2000) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
